ram: RTL and testbench
======================

// Module: ram
//
// PURPOSE
//   Parameterized single-port synchronous RAM; 4 KB (4096 x 8) by default.
//   One shared address bus serves both write and read. Writes take effect on
//   the rising clock edge; reads return registered data one cycle later.
//   Used as a general-purpose scratch/data store on the system clock domain.
//
// PARAMETERS
//   DATA_WIDTH  8                  width of din/dout and of each memory word
//   ADDR_WIDTH  12                 width of addr
//   DEPTH       1<<ADDR_WIDTH      number of words; must be <= 2**ADDR_WIDTH
//
// PORTS
//   clk    in   1           system clock, all logic on rising edge
//   reset  in   1           asynchronous, active-low reset (asserted when 0)
//   we     in   1           write enable, sampled on rising clk
//   din    in   DATA_WIDTH  write data
//   addr   in   ADDR_WIDTH  read/write word address
//   dout   out  DATA_WIDTH  registered read data
//
// BEHAVIOUR
//   - One clock (clk); reset is asynchronous and active-low. While reset==0,
//     dout is forced to 0 immediately and stays 0. Writes are ignored.
//   - Reset does not clear memory contents; array contents after power-up are
//     undefined (X in simulation) until written.
//   - Write: at a rising clk edge with reset==1 and we==1, mem[addr] <= din.
//   - Read: at every rising clk edge with reset==1, dout <= mem[addr].
//     Latency is 1 cycle: dout shows the word addressed at the previous edge.
//     dout holds its value between edges.
//   - Read-during-write to the same address (we==1) is read-first: dout gets
//     the old contents of mem[addr]. The new data is visible one cycle after
//     the write edge.
//   - addr >= DEPTH (only possible when DEPTH < 2**ADDR_WIDTH): the write is
//     dropped and dout <= 0.
//   - Reset released mid-operation: the first rising edge after deassertion
//     performs a normal access. No recovery cycle.
//   - No handshake: an access is accepted every cycle.
//
// CONFIGURATION
//   RAM_WRITE_THROUGH_EN
//     defined:   when we==1, dout <= din on that edge (write-first), so
//                written data appears on dout with 1-cycle latency.
//     undefined: read-first behaviour as described above (the default).
//   - Both variants keep identical ports and reset behaviour.
//
// STRUCTURE
//   - Shared package ram_pkg: the default DATA_WIDTH/ADDR_WIDTH localparams
//     (8/12) and a DEPTH helper constant.
//   - One sub-module ram_core holds the storage array, the write port and the
//     combinational read mux.
//   - Top level ram adds the output register with async active-low reset, the
//     out-of-range guard and the RAM_WRITE_THROUGH_EN option.
//
// TESTING
//   1. Hold reset=0 for 2 cycles with we=1 and addr/din toggling
//      -> dout==0 throughout. Reading those addresses after reset shows no
//      write took effect (X).
//   2. Release reset. Write addr i with din=i+100 for i=0..15, then read
//      addr 0..15 with we=0 -> dout==100..115, each 1 cycle after its addr.
//   3. Write 0xAA to 0x000 and 0x55 to 0xFFF, then read both
//      -> 0xAA and 0x55 (address extremes, no aliasing).
//   4. Write 0x11 to addr 5, then same-cycle we=1 with din=0x22 at addr 5
//      -> dout==0x11 (0x22 with RAM_WRITE_THROUGH_EN). The next read shows 0x22.
//   5. Pull reset low mid-read, asynchronously between edges -> dout drops to 0
//      immediately. After release, addr 5 still reads 0x22 (contents kept).
//   6. Back-to-back alternating write/read on random addresses vs a reference
//      model, 1000 cycles -> zero mismatches.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared defaults for the single-port RAM: word width, address width and
// the depth helper used to size the storage array.
package ram_pkg;

    localparam int unsigned RAM_DATA_WIDTH = 8;
    localparam int unsigned RAM_ADDR_WIDTH = 12;

    // Number of words addressable by an address bus of the given width.
    function automatic int unsigned ram_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    localparam int unsigned RAM_DEPTH = ram_depth(RAM_ADDR_WIDTH);

endpackage

// File: rtl/ram_core.sv
// Storage array for ram: synchronous write port and combinational read mux.
// Contents are never reset; the caller gates the write enable.
module ram_core
    import ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int unsigned DEPTH      = ram_depth(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: store din at addr on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    // Read mux: current contents at addr (old data during a same-edge write).
    always_comb begin
        rdata = mem[addr];
    end

endmodule

// File: rtl/ram.sv
// Single-port synchronous RAM, 1-cycle registered read, read-first by default.
// Reset (active-low, asynchronous) clears only the output register and
// blocks writes; memory contents are preserved.
// Optional macro RAM_WRITE_THROUGH_EN: write-first, dout <= din when we==1.
module ram
    import ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int unsigned DEPTH      = ram_depth(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);

    logic                  in_range;
    logic                  core_we;
    logic [DATA_WIDTH-1:0] rdata;

    // Address guard and write qualification: no writes in reset or out of range.
    always_comb begin
        in_range = ({1'b0, addr} < LIMIT);
        core_we  = we && reset && in_range;
    end

    ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_core (
        .clk   (clk),
        .we    (core_we),
        .addr  (addr),
        .din   (din),
        .rdata (rdata)
    );

    // Output register: cleared asynchronously, zero for out-of-range addresses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout <= '0;
        end else if (!in_range) begin
            dout <= '0;
`ifdef RAM_WRITE_THROUGH_EN
        end else if (we) begin
            dout <= din;
`endif
        end else begin
            dout <= rdata;
        end
    end

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: directed cases plus randomized traffic
// compared against an array-based reference model.
module tb_ram;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        we    = 1'b0;
    logic [7:0]  din   = '0;
    logic [11:0] addr  = '0;
    logic [7:0]  dout;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0] mem_m [4096];
    bit         vld   [4096];

    ram #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (12),
        .DEPTH      (4096)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .din   (din),
        .addr  (addr),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // One access cycle; result compared to the model when the model knows it.
    task automatic access(input string tag, input logic w, input logic [11:0] a,
                          input logic [7:0] d);
        logic [7:0] e;
        bit         known;
`ifdef RAM_WRITE_THROUGH_EN
        if (w) begin
            e = d;
            known = 1'b1;
        end else begin
            e = mem_m[a];
            known = vld[a];
        end
`else
        e = mem_m[a];
        known = vld[a];
`endif
        we = w; addr = a; din = d;
        @(posedge clk); #1;
        if (w) begin
            mem_m[a] = d;
            vld[a] = 1'b1;
        end
        if (known) check(tag, dout, e);
    endtask

    initial begin
        logic [11:0] ra;
        logic [7:0]  rd;

        // Power-up reset: writes attempted while held low, dout stays zero.
        #1 reset = 1'b0;
        #1 check("reset_async", dout, 8'h00);
        for (int i = 0; i < 2; i++) begin
            we = 1'b1; addr = 12'(i); din = 8'(8'hC0 + i);
            @(posedge clk); #1;
            check("reset_hold", dout, 8'h00);
        end
        we = 1'b0;
        @(negedge clk) reset = 1'b1;
        #1;

        // Fill 0..15 with i+100, then read them back.
        for (int i = 0; i < 16; i++) access("fill", 1'b1, 12'(i), 8'(i + 100));
        for (int i = 0; i < 16; i++) begin
            access("readback", 1'b0, 12'(i), 8'h00);
            check("readback_const", dout, 8'(i + 100));
        end

        // Writes during reset must not land: known contents survive.
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            we = 1'b1; addr = 12'(i); din = 8'hEE;
            @(posedge clk); #1;
            check("reset_nowrite_dout", dout, 8'h00);
        end
        we = 1'b0;
        @(negedge clk) reset = 1'b1;
        #1;
        access("reset_kept0", 1'b0, 12'd0, 8'h00);
        check("reset_kept0_const", dout, 8'd100);
        access("reset_kept1", 1'b0, 12'd1, 8'h00);
        check("reset_kept1_const", dout, 8'd101);

        // Address extremes.
        access("ext_w0", 1'b1, 12'h000, 8'hAA);
        access("ext_wf", 1'b1, 12'hFFF, 8'h55);
        access("ext_r0", 1'b0, 12'h000, 8'h00);
        check("ext_r0_const", dout, 8'hAA);
        access("ext_rf", 1'b0, 12'hFFF, 8'h00);
        check("ext_rf_const", dout, 8'h55);

        // Read-during-write on the same address.
        access("rdw_w1", 1'b1, 12'd5, 8'h11);
        access("rdw_w2", 1'b1, 12'd5, 8'h22);
`ifdef RAM_WRITE_THROUGH_EN
        check("rdw_const", dout, 8'h22);
`else
        check("rdw_const", dout, 8'h11);
`endif
        access("rdw_r", 1'b0, 12'd5, 8'h00);
        check("rdw_r_const", dout, 8'h22);

        // Asynchronous reset between edges while dout is nonzero.
        access("async_pre", 1'b0, 12'd5, 8'h00);
        #2 reset = 1'b0;
        #1 check("async_drop", dout, 8'h00);
        @(posedge clk); #1;
        check("async_hold", dout, 8'h00);
        #2 reset = 1'b1;
        #1;
        access("async_post", 1'b0, 12'd5, 8'h00);
        check("async_post_const", dout, 8'h22);

        // Randomized alternating write/read traffic.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) ra = 12'hFFF - 12'($urandom_range(0, 15));
            else                           ra = 12'($urandom_range(0, 47));
            rd = 8'($urandom);
            access("random", (i % 2) == 0, ra, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
